// File: rtl/fifo_pkg.sv
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared definitions for the asynchronous FIFO controllers.
//             Pointer width convention: PTR_LEN = ADDR_LEN + 1, where the
//             extra MSB tells a full FIFO apart from an empty one.
//             The Gray helpers work on a fixed 32-bit container. Narrower
//             pointers are zero-extended on the way in and truncated on the
//             way out. Leading zeros do not disturb either conversion.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int GRAY_FN_LEN = 32;

  function automatic logic [GRAY_FN_LEN-1:0] bin2gray(input logic [GRAY_FN_LEN-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down: bin[i] = ^gray[MSB:i]
  function automatic logic [GRAY_FN_LEN-1:0] gray2bin(input logic [GRAY_FN_LEN-1:0] g);
    logic [GRAY_FN_LEN-1:0] b;
    b[GRAY_FN_LEN-1] = g[GRAY_FN_LEN-1];
    for (int i = GRAY_FN_LEN - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchronizer for a Gray-coded pointer entering this
//             clock domain. Both stages clear to 0 on the synchronous reset.
//  Ports    : clk  - destination-domain clock
//             rst  - synchronous active-high reset
//             d    - asynchronous input bus (Gray coded, one bit changes)
//             q    - synchronized output, two cycles behind d
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
// ============================================================================
//  Module   : fifo_read_ctrl
//  Purpose  : Read-side controller of the asynchronous FIFO (read clock only).
//             It synchronizes the Gray write pointer and keeps the binary and
//             Gray read pointers. It produces a registered empty flag, drives
//             the memory read address and presents words through a
//             registered valid/ready output stage.
//  Ports    : rd_clk, rd_rst   - read clock, synchronous active-high reset
//             wr_ptr_gray      - Gray write pointer (asynchronous)
//             rd_data_mem      - memory read data (combinational on rd_addr)
//             rd_addr          - memory read address
//             rd_ptr_gray      - registered Gray read pointer to the write side
//             rd_empty         - registered, pessimistic empty flag
//             out_data/out_valid/out_ready - downstream handshake
//             rd_level         - words in memory not yet fetched
//  Config   : FIFO_RD_LEVEL_EN - when defined, rd_level is computed.
//                                Otherwise rd_level is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_read_ctrl #(
  parameter int DATA_LEN = 8,
  parameter int ADDR_LEN = 5
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic [ADDR_LEN:0]   wr_ptr_gray,
  input  logic [DATA_LEN-1:0] rd_data_mem,
  output logic [ADDR_LEN-1:0] rd_addr,
  output logic [ADDR_LEN:0]   rd_ptr_gray,
  output logic                rd_empty,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_LEN:0]   rd_level
);

  import fifo_pkg::*;

  localparam int PTR_LEN = ADDR_LEN + 1;

  logic [PTR_LEN-1:0] wq2_wr_ptr;
  logic [PTR_LEN-1:0] rd_bin;
  logic [PTR_LEN-1:0] rd_bin_next;
  logic [PTR_LEN-1:0] rd_gray_next;
  logic               pop;
  logic               rd_inc;

  sync_2ff #(
    .WIDTH (PTR_LEN)
  ) u_wr_ptr_sync (
    .clk (rd_clk),
    .rst (rd_rst),
    .d   (wr_ptr_gray),
    .q   (wq2_wr_ptr)
  );

  assign pop    = out_valid & out_ready;
  // Fetch when memory has data and the output register is free or being
  // drained in the same cycle. This gives one word per cycle with no bubble.
  assign rd_inc = ~rd_empty & (~out_valid | out_ready);

  assign rd_bin_next  = rd_bin + {{ADDR_LEN{1'b0}}, rd_inc};
  assign rd_gray_next = PTR_LEN'(bin2gray(GRAY_FN_LEN'(rd_bin_next)));
  assign rd_addr      = rd_bin[ADDR_LEN-1:0];

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
      rd_empty    <= 1'b1;
      out_data    <= '0;
      out_valid   <= 1'b0;
    end else begin
      rd_bin      <= rd_bin_next;
      rd_ptr_gray <= rd_gray_next;
      // The comparison uses the synchronized (stale) write pointer, so empty
      // can only clear late and never asserts late.
      rd_empty    <= (rd_gray_next == wq2_wr_ptr);
      if (rd_inc) begin
        out_data  <= rd_data_mem;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_LEN-1:0] wq2_wr_bin;
  assign wq2_wr_bin = PTR_LEN'(gray2bin(GRAY_FN_LEN'(wq2_wr_ptr)));
  // Modular subtraction handles pointer wrap. The word held in out_data has
  // already been fetched, so it is not counted.
  assign rd_level   = wq2_wr_bin - rd_bin;
`else
  assign rd_level   = '0;
`endif

endmodule

`default_nettype wire
